// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode constants and load clamp helper for counter_capture_n
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Widths up to 32 bits are handled by working in a 32-bit container.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                 input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/counter_capture_n_if.sv
// rtl/counter_capture_n_if.sv - control and snapshot bundle between counter_capture_n and its user
interface counter_capture_n_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             save;
    logic             cap_ack;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] capture;
    logic             capture_valid;
    logic             wrap;
    logic             cap_overrun;

    modport master (
        output en, up_dn, load, load_val, save, cap_ack,
        input  count, capture, capture_valid, wrap, cap_overrun
    );

    modport slave (
        input  en, up_dn, load, load_val, save, cap_ack,
        output count, capture, capture_valid, wrap, cap_overrun
    );
endinterface

// File: rtl/edge_detect_rise.sv
// rtl/edge_detect_rise.sv - single-cycle rising-edge detector for a level input
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic d_q;

    // Reset to 1 so an input already high when reset releases is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= 1'b1;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/counter_capture_n.sv
// rtl/counter_capture_n.sv - up/down modulo counter with edge-triggered snapshot and ack handshake
module counter_capture_n
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = 0
) (
    input logic                clk,
    input logic                rst_n,
    counter_capture_n_if.slave bus
);
    localparam logic SAT_MODE = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             wrap_q;
    logic             wrap_nxt;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] capture_q;
    logic             capture_valid_q;
    logic             cap_overrun_q;
    logic             cap_event;

    edge_detect_rise u_save_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.save),
        .pulse (cap_event)
    );

    assign load_clamped = WIDTH'(clamp_to_max(32'(bus.load_val), 32'(MAX_VAL)));

    // Limits are compared before stepping so the result never needs a carry bit.
    always_comb begin
        count_nxt = count_q;
        wrap_nxt  = 1'b0;
        if (bus.load) begin
            count_nxt = load_clamped;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (count_q == MAX_VAL) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SAT_MODE ? MAX_VAL : '0;
                end else begin
                    count_nxt = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_nxt  = 1'b1;
                    count_nxt = SAT_MODE ? '0 : MAX_VAL;
                end else begin
                    count_nxt = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    // A capture on the same edge as an ack wins; the ack is taken as covering the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            capture_q       <= '0;
            capture_valid_q <= 1'b0;
            cap_overrun_q   <= 1'b0;
        end else if (cap_event) begin
            capture_q       <= count_q;
            capture_valid_q <= 1'b1;
            if (capture_valid_q && !bus.cap_ack) begin
                cap_overrun_q <= 1'b1;
            end
        end else if (bus.cap_ack) begin
            capture_valid_q <= 1'b0;
        end
    end

    assign bus.count         = count_q;
    assign bus.capture       = capture_q;
    assign bus.capture_valid = capture_valid_q;
    assign bus.wrap          = wrap_q;
    assign bus.cap_overrun   = cap_overrun_q;
endmodule

// File: tb/tb_counter_capture_n.sv
// tb/tb_counter_capture_n.sv - directed vector bench for counter_capture_n
module tb_counter_capture_n;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       up_dn;
        logic       load;
        logic [3:0] load_val;
        logic       save;
        logic       cap_ack;
        logic [3:0] exp_count;
        logic [3:0] exp_capture;
        logic       exp_cv;
        logic       exp_wrap;
        logic       exp_ov;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_vec;
    int   n_bad;

    counter_capture_n_if #(.WIDTH(4)) bus_a ();
    counter_capture_n_if #(.WIDTH(4)) bus_b ();

    counter_capture_n #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .bus   (bus_a.slave)
    );

    counter_capture_n #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic e, input logic u, input logic l,
                                input logic [3:0] lv, input logic s, input logic a,
                                input logic [3:0] c, input logic [3:0] cp, input logic cv,
                                input logic w, input logic ov);
        vec_t v;
        v.rst_n = r; v.en = e; v.up_dn = u; v.load = l; v.load_val = lv;
        v.save = s; v.cap_ack = a;
        v.exp_count = c; v.exp_capture = cp; v.exp_cv = cv; v.exp_wrap = w; v.exp_ov = ov;
        return v;
    endfunction

    task automatic step_a(input vec_t v, input string name, input int idx);
        @(negedge clk);
        rst_a = v.rst_n; bus_a.en = v.en; bus_a.up_dn = v.up_dn; bus_a.load = v.load;
        bus_a.load_val = v.load_val; bus_a.save = v.save; bus_a.cap_ack = v.cap_ack;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_a.count !== v.exp_count || bus_a.capture !== v.exp_capture ||
            bus_a.capture_valid !== v.exp_cv || bus_a.wrap !== v.exp_wrap ||
            bus_a.cap_overrun !== v.exp_ov) begin
            n_bad++;
            $display("FAIL %s[%0d]: got cnt=%0d cap=%0d cv=%0b wrap=%0b ov=%0b, expected cnt=%0d cap=%0d cv=%0b wrap=%0b ov=%0b",
                     name, idx, bus_a.count, bus_a.capture, bus_a.capture_valid, bus_a.wrap,
                     bus_a.cap_overrun, v.exp_count, v.exp_capture, v.exp_cv, v.exp_wrap, v.exp_ov);
        end
    endtask

    task automatic step_b(input logic r, input logic e, input logic u, input logic l,
                          input logic [3:0] lv, input logic [3:0] exp_c, input logic exp_w,
                          input string name);
        @(negedge clk);
        rst_b = r; bus_b.en = e; bus_b.up_dn = u; bus_b.load = l; bus_b.load_val = lv;
        bus_b.save = 1'b0; bus_b.cap_ack = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_b.count !== exp_c || bus_b.wrap !== exp_w) begin
            n_bad++;
            $display("FAIL %s: got cnt=%0d wrap=%0b, expected cnt=%0d wrap=%0b",
                     name, bus_b.count, bus_b.wrap, exp_c, exp_w);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.en = 0; bus_a.up_dn = 0; bus_a.load = 0; bus_a.load_val = 0;
        bus_a.save = 0; bus_a.cap_ack = 0;
        bus_b.en = 0; bus_b.up_dn = 0; bus_b.load = 0; bus_b.load_val = 0;
        bus_b.save = 0; bus_b.cap_ack = 0;

        // Free-running wrap count from reset.
        step_a(mk(0,0,0,0,0,0,0, 0,0,0,0,0), "reset", 0);
        for (int i = 1; i <= 17; i++) begin
            step_a(mk(1,1,1,0,0,0,0, 4'(i % 16),0,0,(i == 16),0), "count_up", i);
        end

        //          rst en up ld lv  sv ack  cnt cap cv wr ov
        tbl.push_back(mk(0,0,0,0, 0, 0,0,   0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,1, 5, 0,0,   5, 0,0,0,0));
        tbl.push_back(mk(1,1,1,0, 0, 1,0,   6, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 0, 1,0,   7, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 0, 1,0,   8, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 0, 1,0,   9, 5,1,0,0));
        tbl.push_back(mk(1,1,1,0, 0, 1,0,  10, 5,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 0,1,  10, 5,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 0,1,  10, 5,0,0,0));
        tbl.push_back(mk(1,0,0,1, 7, 0,0,   7, 5,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 1,0,   7, 7,1,0,0));
        tbl.push_back(mk(1,0,0,1, 3, 0,0,   3, 7,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 1,0,   3, 3,1,0,1));
        tbl.push_back(mk(1,1,1,1, 9, 0,0,   9, 3,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0, 1,1,   9, 9,1,0,1));
        tbl.push_back(mk(1,0,0,0, 0, 0,1,   9, 9,0,0,1));
        tbl.push_back(mk(1,0,0,1,12, 1,0,  12, 9,1,0,1));
        tbl.push_back(mk(0,0,0,0, 0, 1,0,   0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 1,0,   0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 0,0,   0, 0,0,0,0));
        tbl.push_back(mk(1,1,0,0, 0, 0,0,  15, 0,0,1,0));
        tbl.push_back(mk(1,1,0,0, 0, 0,0,  14, 0,0,0,0));
        tbl.push_back(mk(1,1,1,1, 2, 0,0,   2, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 1,0,   2, 2,1,0,0));
        tbl.push_back(mk(1,0,0,0, 0, 0,0,   2, 2,1,0,0));
        tbl.push_back(mk(0,0,0,1, 3, 1,0,   0, 0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i], "table", i);
        end

        // Saturating instance with clamped load.
        step_b(0,0,0,0, 0, 0,0, "sat_reset");
        step_b(1,0,0,1,12, 9,0, "sat_load_clamp");
        for (int i = 0; i < 3; i++) begin
            step_b(1,1,1,0, 0, 9,1, "sat_hold_top");
        end
        step_b(1,1,0,0, 0, 8,0, "sat_down");
        step_b(1,0,0,1, 0, 0,0, "sat_load0");
        step_b(1,1,0,0, 0, 0,1, "sat_hold_bottom");
        step_b(1,1,1,0, 0, 1,0, "sat_up");
        step_b(1,0,0,1, 4, 4,0, "sat_load_inrange");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
